// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and small helper functions.
// Intended for reuse by both the receiver and the transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  // Number of words packed into one output group.
  function automatic int num_words(input int w_out, input int bits);
    return w_out / bits;
  endfunction

  // Even parity over up to 32 data bits (zero-extend narrower words).
  function automatic logic even_parity(input logic [31:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Line conditioning for the UART receiver: 2-flop synchronizer on rx and the
// per-bit decision value. With UART_RX_MAJORITY_EN defined, the decision value
// is a 2-of-3 vote over the current and two previous synchronized samples;
// otherwise it is the synchronized line itself.
module uart_rx_sampler (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic rxs,
  output logic sample
);

  logic sync1_r;
  logic sync2_r;

  // Two-stage synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
    end else begin
      sync1_r <= rx;
      sync2_r <= sync1_r;
    end
  end

  assign rxs = sync2_r;

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist_r;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // History of the two previous synchronized samples for the vote.
  always_ff @(posedge clk) begin
    if (rst) begin
      hist_r <= 2'b11;
    end else begin
      hist_r <= {hist_r[0], sync2_r};
    end
  end

  assign sample = maj3(sync2_r, hist_r[0], hist_r[1]);
`else
  assign sample = sync2_r;
`endif

endmodule

// File: rtl/uart_rx_deframer.sv
// UART receive deframer: start/data/parity/stop deframing with even-parity
// check, assembly of NUM_WORDS words into a W_OUT-bit group, and a
// valid/ready output stream with overrun and frame-error pulses.
// Optional build macro: UART_RX_MAJORITY_EN (majority-vote bit decisions,
// decision point moved one cycle later).
module uart_rx_deframer
  import uart_pkg::*;
#(
  parameter int CLOCKS_PER_PULSE = 16,
  parameter int BITS_PER_WORD    = 8,
  parameter int W_OUT            = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx,
  output logic [W_OUT-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_error,
  output logic             frame_err,
  output logic             overrun
);

  localparam int NUM_WORDS = num_words(W_OUT, BITS_PER_WORD);
  localparam int CNT_W     = $clog2(CLOCKS_PER_PULSE);
  localparam int BIT_W     = $clog2(BITS_PER_WORD + 1);
  localparam int WIDX_W    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

`ifdef UART_RX_MAJORITY_EN
  localparam int SAMPLE_OFS = 1;
`else
  localparam int SAMPLE_OFS = 0;
`endif

  // The start decision carries the vote offset; later bit decisions sit a
  // whole bit period apart and so inherit the same offset automatically.
  localparam logic [CNT_W-1:0] START_PT = CNT_W'(CLOCKS_PER_PULSE / 2 - 1 + SAMPLE_OFS);
  localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLOCKS_PER_PULSE - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(BITS_PER_WORD - 1);
  localparam logic [WIDX_W-1:0] LAST_WORD = WIDX_W'(NUM_WORDS - 1);

  rx_state_t                                   state_r;
  logic [CNT_W-1:0]                            cnt_r;
  logic [BIT_W-1:0]                            bit_r;
  logic [WIDX_W-1:0]                           widx_r;
  logic [BITS_PER_WORD-1:0]                    word_r;
  logic [NUM_WORDS-1:0][BITS_PER_WORD-1:0]     group_r;
  logic                                        perr_r;
  logic                                        err_acc_r;

  logic                                        rxs_s;
  logic                                        sample_s;
  logic [NUM_WORDS-1:0][BITS_PER_WORD-1:0]     next_group_s;

  uart_rx_sampler u_sampler (
    .clk    (clk),
    .rst    (rst),
    .rx     (rx),
    .rxs    (rxs_s),
    .sample (sample_s)
  );

  // Group contents with the just-received word placed at the current index.
  always_comb begin
    next_group_s = group_r;
    for (int i = 0; i < NUM_WORDS; i++) begin
      if (widx_r == WIDX_W'(i)) begin
        next_group_s[i] = word_r;
      end else begin
        next_group_s[i] = group_r[i];
      end
    end
  end

  // Deframing FSM, group assembly and output stream registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      cnt_r     <= '0;
      bit_r     <= '0;
      widx_r    <= '0;
      word_r    <= '0;
      group_r   <= '0;
      perr_r    <= 1'b0;
      err_acc_r <= 1'b0;
      m_data    <= '0;
      m_valid   <= 1'b0;
      m_error   <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      // Handshake completes; a group finishing this cycle re-raises valid below.
      if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end

      case (state_r)
        IDLE: begin
          cnt_r <= '0;
          if (!rxs_s) begin
            state_r <= START;
          end
        end

        START: begin
          if (cnt_r == START_PT) begin
            cnt_r <= '0;
            bit_r <= '0;
            // A high line at mid-start is a glitch, not a frame.
            state_r <= sample_s ? IDLE : DATA;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end

        DATA: begin
          if (cnt_r == BIT_END) begin
            cnt_r  <= '0;
            word_r <= {sample_s, word_r[BITS_PER_WORD-1:1]};
            if (bit_r == LAST_BIT) begin
              bit_r   <= '0;
              state_r <= PARITY;
            end else begin
              bit_r <= bit_r + BIT_W'(1);
            end
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end

        PARITY: begin
          if (cnt_r == BIT_END) begin
            cnt_r   <= '0;
            perr_r  <= sample_s ^ even_parity(32'(word_r));
            state_r <= STOP;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end

        STOP: begin
          if (cnt_r == BIT_END) begin
            cnt_r   <= '0;
            state_r <= IDLE;
            if (sample_s) begin
              if (widx_r == LAST_WORD) begin
                widx_r    <= '0;
                err_acc_r <= 1'b0;
                if (!m_valid || m_ready) begin
                  m_data  <= next_group_s;
                  m_error <= err_acc_r | perr_r;
                  m_valid <= 1'b1;
                end else begin
                  overrun <= 1'b1;
                end
              end else begin
                group_r   <= next_group_s;
                err_acc_r <= err_acc_r | perr_r;
                widx_r    <= widx_r + WIDX_W'(1);
              end
            end else begin
              // Broken frame: drop the word and restart group alignment.
              frame_err <= 1'b1;
              widx_r    <= '0;
              err_acc_r <= 1'b0;
            end
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end

        default: begin
          state_r <= IDLE;
          cnt_r   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Directed bench for uart_rx_deframer (16 clocks/bit, 8-bit words, 24-bit groups).
module tb_uart_rx_deframer;

  localparam int CPP = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx = 1'b1;
  logic [23:0] m_data;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic        m_error;
  logic        frame_err;
  logic        overrun;

  int checks = 0;
  int errors = 0;

  // Event monitor counts (free running; tests compare deltas).
  int          valid_cnt = 0;
  int          fe_cnt = 0;
  int          ov_cnt = 0;
  logic        prev_valid = 1'b0;
  logic [23:0] last_data = 24'h0;
  logic        last_err = 1'b0;

  uart_rx_deframer #(
    .CLOCKS_PER_PULSE (CPP),
    .BITS_PER_WORD    (8),
    .W_OUT            (24)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_error   (m_error),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (m_valid && !prev_valid) begin
      valid_cnt = valid_cnt + 1;
      last_data = m_data;
      last_err  = m_error;
    end
    prev_valid = m_valid;
    if (frame_err) fe_cnt = fe_cnt + 1;
    if (overrun) ov_cnt = ov_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic line_bit(input logic b);
    rx = b;
    repeat (CPP) @(negedge clk);
  endtask

  // One frame: start, 8 data LSB first, even parity, 3 stop bits.
  task automatic send_word(input logic [7:0] w, input logic flip_par, input logic stop0);
    line_bit(1'b0);
    for (int i = 0; i < 8; i++) line_bit(w[i]);
    line_bit((^w) ^ flip_par);
    line_bit(~stop0);
    line_bit(1'b1);
    line_bit(1'b1);
  endtask

  task automatic send_group(input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2);
    send_word(w0, 1'b0, 1'b0);
    send_word(w1, 1'b0, 1'b0);
    send_word(w2, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
  endtask

  int base_v;
  int base_fe;
  int base_ov;

  task automatic snap();
    base_v  = valid_cnt;
    base_fe = fe_cnt;
    base_ov = ov_cnt;
  endtask

  initial begin
    // Reset state
    repeat (4) @(negedge clk);
    check_eq("rst_valid", 32'(m_valid), 32'h0);
    check_eq("rst_data", 32'(m_data), 32'h0);
    check_eq("rst_error", 32'(m_error), 32'h0);
    check_eq("rst_pulses", 32'({frame_err, overrun}), 32'h0);
    rst = 1'b0;
    repeat (8) @(negedge clk);

    // Clean group
    snap();
    send_group(8'hA5, 8'h3C, 8'h01);
    check_eq("clean_vcnt", 32'(valid_cnt - base_v), 32'd1);
    check_eq("clean_data", 32'(last_data), 32'h0013CA5);
    check_eq("clean_err", 32'(last_err), 32'h0);
    check_eq("clean_fe_ov", 32'((fe_cnt - base_fe) + (ov_cnt - base_ov)), 32'd0);

    // Parity error on word 1
    snap();
    send_word(8'hA5, 1'b0, 1'b0);
    send_word(8'h3C, 1'b1, 1'b0);
    send_word(8'h01, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    check_eq("par_vcnt", 32'(valid_cnt - base_v), 32'd1);
    check_eq("par_data", 32'(last_data), 32'h0013CA5);
    check_eq("par_err", 32'(last_err), 32'h1);

    // Frame error on word 1's stop bit, then a clean resynced group
    snap();
    send_word(8'hA5, 1'b0, 1'b0);
    send_word(8'h3C, 1'b0, 1'b1);
    check_eq("fe_cnt", 32'(fe_cnt - base_fe), 32'd1);
    check_eq("fe_novalid", 32'(valid_cnt - base_v), 32'd0);
    send_group(8'h11, 8'h22, 8'h33);
    check_eq("fe_resync_vcnt", 32'(valid_cnt - base_v), 32'd1);
    check_eq("fe_resync_data", 32'(last_data), 32'h0332211);
    check_eq("fe_resync_err", 32'(last_err), 32'h0);

    // Short low glitch on the idle line
    snap();
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (200) @(negedge clk);
    check_eq("glitch_quiet", 32'((valid_cnt - base_v) + (fe_cnt - base_fe) + (ov_cnt - base_ov)), 32'd0);

    // Overrun with downstream stalled
    snap();
    m_ready = 1'b0;
    send_group(8'h03, 8'h02, 8'h01);
    send_group(8'h06, 8'h05, 8'h04);
    check_eq("ovr_valid", 32'(m_valid), 32'h1);
    check_eq("ovr_data_hold", 32'(m_data), 32'h0010203);
    check_eq("ovr_err", 32'(m_error), 32'h0);
    check_eq("ovr_cnt", 32'(ov_cnt - base_ov), 32'd1);
    check_eq("ovr_vcnt", 32'(valid_cnt - base_v), 32'd1);
    m_ready = 1'b1;
    check_eq("ovr_valid_before", 32'(m_valid), 32'h1);
    @(negedge clk);
    check_eq("ovr_valid_drop", 32'(m_valid), 32'h0);

    // Reset mid-frame during word 1's data bits
    snap();
    send_word(8'hAA, 1'b0, 1'b0);
    line_bit(1'b0);
    line_bit(1'b1);
    line_bit(1'b0);
    rst = 1'b1;
    rx = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("mid_rst_valid", 32'(m_valid), 32'h0);
    check_eq("mid_rst_data", 32'(m_data), 32'h0);
    check_eq("mid_rst_error", 32'(m_error), 32'h0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check_eq("mid_rst_pulses", 32'((fe_cnt - base_fe) + (ov_cnt - base_ov)), 32'd0);
    send_group(8'h77, 8'h88, 8'h99);
    check_eq("post_rst_vcnt", 32'(valid_cnt - base_v), 32'd1);
    check_eq("post_rst_data", 32'(last_data), 32'h0998877);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_deframer.md
Name: uart_rx_deframer

Overview:
- Serial receiver stage that consumes the line produced by the team's UART transmitter.
- Each word frame on the line is:
  - 1 start bit (0)
  - BITS_PER_WORD data bits, LSB first
  - 1 even-parity bit (XOR of the data bits)
  - stop bits (1), 3 of them in the default 8-bit configuration
- The block oversamples the line, deframes and checks each word, and assembles NUM_WORDS words into one W_OUT-bit group.
- The group is presented on a valid/ready stream interface to downstream logic.

Parameters:
- CLOCKS_PER_PULSE, 16: clk cycles per bit; must be even and >= 4.
- BITS_PER_WORD, 8: data bits per frame.
- W_OUT, 24: group width; NUM_WORDS = W_OUT / BITS_PER_WORD (local); W_OUT must be an exact multiple of BITS_PER_WORD.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- rx  in  1  asynchronous serial line, idle high.
- m_data  out  NUM_WORDS x BITS_PER_WORD  received group; word 0 = first received, in the low bits.
- m_valid  out  1  group available.
- m_ready  in  1  downstream accepts the group.
- m_error  out  1  qualified by m_valid: at least one word in the group had a parity mismatch.
- frame_err  out  1  one-cycle pulse: stop bit sampled 0.
- overrun  out  1  one-cycle pulse: a group completed while the previous group was still unaccepted.

Behaviour:
- Interface (already decided): one clock, clk; reset rst is synchronous and active-high.
- Reset values: m_valid=0, m_error=0, m_data=0, frame_err=0, overrun=0. Reset also sets state=IDLE, all counters=0, word index=0 and synchronizer flops=1.
- rx passes through a 2-flop synchronizer; all decisions use the synchronized value rxs. This adds 2 cycles of latency.
- States: IDLE, START, DATA, PARITY, STOP.
  - IDLE: rxs==0 -> START, clock counter=0.
  - START: when counter==CLOCKS_PER_PULSE/2-1, sample. If the sample is 1 (false start/glitch) -> IDLE; else -> DATA, counter=0.
  - DATA: sample when counter==CLOCKS_PER_PULSE-1, shifting the sample into the word MSB (LSB-first line order). After BITS_PER_WORD samples -> PARITY.
  - PARITY: sample one bit; perr = sample XOR (^word).
  - STOP: sample one bit.
    - Stop bit 1: store the word at the current word index and OR perr into a group error accumulator. Then -> IDLE.
    - Stop bit 0: pulse frame_err, discard the word, reset word index and error accumulator to 0 (resync the group). Then -> IDLE.
- Only one stop bit is checked. The extra stop bits are absorbed by IDLE waiting for the next falling edge.
- Group completion (stop bit of word NUM_WORDS-1 accepted):
  - If m_valid==0: in the next cycle set m_data=group, m_error=accumulator, m_valid=1; word index and accumulator return to 0.
  - If m_valid==1 and m_ready==0: pulse overrun, drop the new group, hold the old one.
  - If m_valid==1 and m_ready==1 in the same cycle: accept the new group, m_valid stays 1, no overrun.
- Handshake: m_valid drops in the cycle after m_valid&&m_ready. m_data and m_error stay stable while m_valid=1 and m_ready=0.
- Latency: m_valid rises 1 cycle after the mid-point sample of the last stop bit.
- Counter widths:
  - $clog2(CLOCKS_PER_PULSE) for the clock counter.
  - $clog2(BITS_PER_WORD+1) for the bit counter.
  - $clog2(NUM_WORDS) for the word index, minimum 1 bit.
  - No counter wraps outside these bounds.
- Reset mid-frame: partial word and partial group are discarded, and no pulses are emitted.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined: each bit decision (start confirm, data, parity, stop) is a 2-of-3 majority of rxs at counter values mid-1, mid and mid+1, where mid is the nominal sample point. The decision is taken at mid+1, which shifts internal timing by 1 cycle; m_valid latency grows by 1 cycle.
- Undefined: a single sample at the nominal point.

Decomposition:
- Package uart_pkg holds:
  - the state enum rx_state_t (IDLE, START, DATA, PARITY, STOP);
  - localparam function num_words(w_out, bits);
  - function even_parity(data).
- The transmitter may reuse the package.
- One sub-module, uart_rx_sampler, contains the 2-flop synchronizer and, when UART_RX_MAJORITY_EN is defined, the majority-vote sampling. Its outputs are rxs and a sample value.

Test Plan:
- CLOCKS_PER_PULSE=16, W_OUT=24. Send 0xA5, 0x3C, 0x01 with correct parity and 3 stop bits, m_ready=1 -> one m_valid pulse, m_data=0x013CA5, m_error=0, no frame_err or overrun.
- Same words, parity bit of 0x3C inverted -> m_data=0x013CA5 with m_error=1.
- Stop bit of word 1 forced to 0 -> frame_err pulse ~8 cycles into that stop bit, no m_valid. Next clean group 0x11, 0x22, 0x33 -> m_data=0x332211.
- 4-cycle low glitch on idle rx -> no state leaves IDLE beyond START, no outputs.
- m_ready=0, send group 0x010203 then 0x040506 -> m_data holds 0x010203, one overrun pulse. Raise m_ready -> m_valid drops next cycle.
- Assert rst during DATA of word 1 -> all outputs 0. A following clean group is received correctly.
